// File: rtl/hazard_controller.sv
// Pipeline hazard controller: forwarding selects, load-use/branch stalls and a
// wait-state FSM for the data memory. Define HAZ_PERF_CNT_EN to add stallCount.
module hazard_controller #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  writeRegE,
    input  logic [4:0]  writeRegM,
    input  logic [4:0]  writeRegW,
    input  logic        regWriteE,
    input  logic        regWriteM,
    input  logic        regWriteW,
    input  logic        memToRegE,
    input  logic        memToRegM,
    input  logic        branchD,
    input  logic        memReqM,
    input  logic        memReadyM,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic        forwardAD,
    output logic        forwardBD,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushE,
    output logic        flushW,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0] stallCount,
`endif
    output logic        memErr
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lwstall, brstall, memstall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       wm, input logic [4:0] rm,
                                           input logic       ww, input logic [4:0] rw);
        if (src != 5'd0 && wm && src == rm)      return 2'b10;
        else if (src != 5'd0 && ww && src == rw) return 2'b01;
        else                                     return 2'b00;
    endfunction

    function automatic logic hits_d(input logic [4:0] r, input logic [4:0] a,
                                    input logic [4:0] b);
        return (r != 5'd0) && (r == a || r == b);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: if (memReqM && !memReadyM) begin
                state_nxt = S_WAIT;
                cnt_nxt   = '0;
            end
            S_WAIT: begin
                if (memReadyM)                                state_nxt = S_IDLE;
                else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1))   state_nxt = S_ERR;
                else                                          cnt_nxt   = cnt + 1'b1;
            end
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Hazard terms are raw; reset gating happens once at the outputs.
    always_comb begin
        lwstall  = memToRegE && rtE != 5'd0 && (rtE == rsD || rtE == rtD);
        brstall  = branchD && ((regWriteE && hits_d(writeRegE, rsD, rtD)) ||
                               (memToRegM && hits_d(writeRegM, rsD, rtD)));
        memstall = (state == S_IDLE && memReqM && !memReadyM) ||
                   (state == S_WAIT && !memReadyM) ||
                   (state == S_ERR);
    end

    always_comb begin
        forwardAE = '0;
        forwardBE = '0;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        memErr    = 1'b0;
        if (!reset) begin
            forwardAE = fwd_sel(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
            forwardBE = fwd_sel(rtE, regWriteM, writeRegM, regWriteW, writeRegW);
            forwardAD = rsD != 5'd0 && regWriteM && rsD == writeRegM;
            forwardBD = rtD != 5'd0 && regWriteM && rtD == writeRegM;
            stallF    = lwstall || brstall || memstall;
            stallD    = stallF;
            stallE    = memstall;
            stallM    = memstall;
            // A frozen pipe must hold E, not bubble it; W gets the bubble instead.
            flushE    = (lwstall || brstall) && !memstall;
            flushW    = memstall;
            memErr    = state == S_ERR;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stallCount <= '0;
        else if (stallD && stallCount != 32'hFFFF_FFFF)
            stallCount <= stallCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (TIMEOUT_CYCLES=4); expected output
// vectors are queued with each stimulus step and popped at the sample point.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic       regWriteE, regWriteM, regWriteW, memToRegE, memToRegM;
    logic       branchD, memReqM, memReadyM;
    logic [1:0] forwardAE, forwardBE;
    logic       forwardAD, forwardBD, stallF, stallD, stallE, stallM;
    logic       flushE, flushW, memErr;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stallCount;
`endif

    typedef struct packed {
        logic [1:0] ae, be;
        logic ad, bd, sf, sd, se, sm, fe, fw, err;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_controller #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .memToRegE(memToRegE), .memToRegM(memToRegM),
        .branchD(branchD), .memReqM(memReqM), .memReadyM(memReadyM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushE(flushE), .flushW(flushW),
`ifdef HAZ_PERF_CNT_EN
        .stallCount(stallCount),
`endif
        .memErr(memErr)
    );

    function automatic exp_t mk(input logic [1:0] ae, input logic [1:0] be,
                                input logic ad, input logic bd, input logic sfd,
                                input logic sem, input logic fe, input logic fw,
                                input logic err);
        exp_t e;
        e.ae = ae; e.be = be; e.ad = ad; e.bd = bd;
        e.sf = sfd; e.sd = sfd; e.se = sem; e.sm = sem;
        e.fe = fe; e.fw = fw; e.err = err;
        return e;
    endfunction

    localparam exp_t ZERO  = '0;
    localparam exp_t LDUSE = 13'b0000_0011_00100;  // stallF/D + flushE
    localparam exp_t MEMST = 13'b0000_0011_11010;  // stallF/D/E/M + flushW

    task automatic clear_in();
        {rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW} = '0;
        {regWriteE, regWriteM, regWriteW, memToRegE, memToRegM} = '0;
        {branchD, memReqM, memReadyM} = '0;
    endtask

    // Called just after a falling edge, once the inputs for this cycle are set.
    task automatic step(input string tag, input exp_t e);
        exp_t want, got;
        q.push_back(e);
        #1;
        got = {forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD,
               stallE, stallM, flushE, flushW, memErr};
        want = q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        // Hot inputs during reset must not leak to the outputs.
        rsE = 5'd5; writeRegM = 5'd5; regWriteM = 1'b1;
        memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8; memReqM = 1'b1;
        repeat (2) @(negedge clk);
        step("reset_outputs", ZERO);

        @(negedge clk); reset = 1'b0; clear_in();
        step("idle_after_reset", ZERO);

        // Forwarding priority
        @(negedge clk);
        rsE = 5'd5; writeRegM = 5'd5; regWriteM = 1'b1; writeRegW = 5'd5; regWriteW = 1'b1;
        step("fwdAE_M_priority", mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); regWriteM = 1'b0;
        step("fwdAE_from_W", mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); rsE = 5'd0; rtE = 5'd5;
        step("fwd_r0_and_BE_W", mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk); clear_in(); writeRegM = 5'd0; regWriteM = 1'b1; rtD = 5'd0;
        step("fwd_r0_dest", ZERO);

        // Load-use
        @(negedge clk); clear_in(); memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        step("loaduse_stall", LDUSE);
        @(negedge clk); memToRegE = 1'b0;
        step("loaduse_clear", ZERO);
        @(negedge clk); memToRegE = 1'b1; rtE = 5'd0; rsD = 5'd0; rtD = 5'd0;
        step("loaduse_r0", ZERO);

        // Branch hazards
        @(negedge clk); clear_in(); branchD = 1'b1; rsD = 5'd3; regWriteE = 1'b1; writeRegE = 5'd3;
        step("branch_stall_E", LDUSE);
        @(negedge clk); regWriteE = 1'b0; writeRegM = 5'd3; regWriteM = 1'b1; memToRegM = 1'b0;
        step("branch_fwdAD", mk(2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk); memToRegM = 1'b1; rtD = 5'd3;
        step("branch_stall_loadM", mk(2'b00, 2'b00, 1, 1, 1, 0, 1, 0, 0));

        // Three-cycle memory wait, with a load-use hazard during the freeze
        @(negedge clk); clear_in(); memReqM = 1'b1;
        step("memwait_1", MEMST);
        @(negedge clk); memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        step("memwait_2_no_flushE", MEMST);
        @(negedge clk); memToRegE = 1'b0;
        step("memwait_3", MEMST);
        @(negedge clk); memReadyM = 1'b1;
        step("memwait_ready", ZERO);
        @(negedge clk);
        step("mem_ready_same_cycle", ZERO);

        // Longest access that still completes: 1 IDLE + 3 WAIT stalls
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); memReadyM = 1'b0;
            step($sformatf("memlong_%0d", i), MEMST);
        end
        @(negedge clk); memReadyM = 1'b1;
        step("memlong_ready", ZERO);

        // Timeout into ERR
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); memReadyM = 1'b0;
            step($sformatf("timeout_%0d", i), MEMST);
        end
        @(negedge clk);
        step("err_entered", mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 1));
        @(negedge clk); memReqM = 1'b0; memReadyM = 1'b1;
        step("err_sticky", mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 1));
        @(negedge clk); reset = 1'b1;
        step("err_reset_held", ZERO);
        @(negedge clk); reset = 1'b0; memReqM = 1'b0;
        step("err_reset_released", ZERO);
        @(negedge clk); memReqM = 1'b1; memReadyM = 1'b1;
        step("idle_after_err", ZERO);

        // Reset in the middle of WAIT
        @(negedge clk); memReadyM = 1'b0;
        step("midwait_1", MEMST);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; memReadyM = 1'b1;
        step("midwait_reset_idle", ZERO);

`ifdef HAZ_PERF_CNT_EN
        @(negedge clk); clear_in(); reset = 1'b1;
        @(negedge clk); reset = 1'b0; memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        repeat (3) @(negedge clk);
        memToRegE = 1'b0; memReqM = 1'b1;
        repeat (2) @(negedge clk);
        memReadyM = 1'b1;
        @(negedge clk); clear_in(); #1;
        vectors++;
        assert (stallCount === 32'd5) else begin
            miscompares++;
            $error("FAIL stallCount: got %0d expected 5", stallCount);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
